reg_writeback: RTL and testbench
================================

# reg_writeback

Write-port controller that drives the single write port of the 32x32 general-purpose register file. It accepts ALU results (no backpressure) and memory-load results (valid/ready) and buffers loads in a small FIFO. It arbitrates both sources onto one registered write per cycle and suppresses writes to register 0. It sits between the execute/memory stages and the register file, and optionally reports pending-write hazards to decode.

## Interface
- `DEPTH`, 4: load FIFO entries; power of two, 2..16.
- `STARVE_MAX`, 3: consecutive cycles the FIFO may be non-empty without a pop before `alu_stall` asserts; 1..15.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_valid`  in  1  ALU result present this cycle; always accepted.
- `alu_reg`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_stall`  out  1  request upstream to withhold `alu_valid` next cycle.
- `ld_valid`  in  1  load result present.
- `ld_ready`  out  1  FIFO can accept; transfer on `ld_valid && ld_ready`.
- `ld_reg`  in  5  load destination register.
- `ld_data`  in  32  load data.
- `write_reg`  out  5  to register file write address.
- `reg_write_flag`  out  1  to register file write enable.
- `data`  out  32  to register file write data.
- `read_reg1`, `read_reg2`  in  5 each  decode read addresses (hazard query).
- `busy1`, `busy2`  out  1 each  pending write targets `read_reg1` / `read_reg2`.

## Operation
- Every cycle, select at most one source:
  - ALU if `alu_valid`.
  - Otherwise FIFO head if not empty (pop).
- Selected entry is registered into `write_reg`/`data`.
- `reg_write_flag` <= 1 only if the selected destination != 0.
- With no selection, or a destination of 0: `reg_write_flag` <= 0, and `write_reg`/`data` hold their previous values.
- A write to register 0 is consumed (popped or accepted) but never issued.
- `ld_ready` = FIFO not full. A push when full is impossible; there is no pass-through to the output.
- Push and pop in the same cycle are legal at any non-full occupancy. Occupancy is unchanged.
- FIFO pointers wrap modulo `DEPTH`. Count is `$clog2(DEPTH)+1` bits.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on pop or when the FIFO is empty. Saturates at `STARVE_MAX`.
  - `alu_stall` = (counter == `STARVE_MAX`).
  - If `alu_valid` arrives while `alu_stall` is high, the ALU still wins and no data is lost. `alu_stall` stays high until a pop.
- Ordering:
  - Loads are written in acceptance order.
  - ALU and load writes to the same register take effect in issue order. Upstream guarantees no WAW across sources.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `reg_write_flag`=0, `write_reg`=0, `data`=0, `alu_stall`=0.
  - FIFO empty, counter=0.
  - `ld_ready`=0 while `rst_n` is low; `ld_ready`=1 from the first edge after release.
  - `busy1`/`busy2`=0.
- Reset mid-operation discards all FIFO contents and any pending output write.
- ALU latency:
  - `alu_valid` in cycle N → `reg_write_flag` high in cycle N+1.
  - The register file captures the write at the edge ending N+1.
- Load latency, minimum: accepted in N, FIFO previously empty, no ALU in N+1 → popped in N+1, output in N+2.
- Output registers are valid for exactly one cycle per issued write.
- `busy1`/`busy2` are combinational from `read_reg*`. A busy signal is high when both hold:
  - The register is nonzero.
  - It matches a valid FIFO entry, or matches `write_reg` while `reg_write_flag`=1.

## Configuration
- `WB_HAZARD_EN`:
  - Defined: `busy1`/`busy2` comparators over the FIFO entries and the output register are compiled in as specified.
  - Undefined: `busy1`/`busy2` are tied to 0, the comparators are removed, and ports remain.

## Test plan
- Reset, then `alu_valid`=1, `alu_reg`=5, `alu_data`=0xDEADBEEF for one cycle → next cycle `reg_write_flag`=1, `write_reg`=5, `data`=0xDEADBEEF; then `reg_write_flag`=0.
- `alu_reg`=0, `alu_data`=0x1234 → `reg_write_flag` stays 0. Load to reg 0 → popped, no write, count decrements.
- Push loads to r1..r4 (DEPTH=4) with `alu_valid` held high → `ld_ready`=0 after the 4th push. `alu_stall`=1 on the 3rd cycle with no pop. Drop `alu_valid` → loads are written r1,r2,r3,r4 on consecutive cycles and `alu_stall` clears after the first pop.
- FIFO at 2 entries, push and pop in the same cycle → occupancy stays 2, data order preserved across pointer wrap (≥3 full laps).
- `WB_HAZARD_EN` defined, load to r7 pending, `read_reg1`=7, `read_reg2`=0 → `busy1`=1, `busy2`=0; `busy1` falls the cycle after r7 leaves the output register. Undefined → always 0.
- Assert `rst_n`=0 asynchronously mid-drain with 3 entries → outputs go 0 immediately; after release, no stale writes issue and `ld_ready`=1.

Source files
------------

// File: rtl/reg_writeback.sv
// Register-file write-port controller: ALU results take priority, and loads are buffered in a FIFO.
// Hazard reporting to decode is compiled in only when WB_HAZARD_EN is defined.
module reg_writeback #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_reg,
    input  logic [31:0] ld_data,
    output logic [4:0]  write_reg,
    output logic        reg_write_flag,
    output logic [31:0] data,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic        busy1,
    output logic        busy2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

    logic [4:0]    mem_reg_q  [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    starve_q, starve_d;
    logic          rdy_q;
    logic          write_flag_q, write_flag_d;
    logic [4:0]    write_reg_q, write_reg_d;
    logic [31:0]   data_q, data_d;

    logic          empty, full, push, pop, sel_valid;
    logic [4:0]    sel_reg;
    logic [31:0]   sel_data;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    // rdy_q keeps ld_ready low during reset and until the first edge after release
    assign ld_ready = rdy_q && !full;
    assign push     = ld_valid && ld_ready;
    assign pop      = !alu_valid && !empty;

    assign alu_stall      = (starve_q == STARVE_LIM);
    assign reg_write_flag = write_flag_q;
    assign write_reg      = write_reg_q;
    assign data           = data_q;

    always_comb begin
        sel_valid = 1'b0;
        sel_reg   = '0;
        sel_data  = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_reg   = alu_reg;
            sel_data  = alu_data;
        end else if (!empty) begin
            sel_valid = 1'b1;
            sel_reg   = mem_reg_q[rd_ptr_q];
            sel_data  = mem_data_q[rd_ptr_q];
        end

        // r0 writes are consumed but never issued; the output registers keep their last value
        write_flag_d = sel_valid && (sel_reg != 5'd0);
        write_reg_d  = write_flag_d ? sel_reg  : write_reg_q;
        data_d       = write_flag_d ? sel_data : data_q;

        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q == STARVE_LIM) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            rdy_q        <= 1'b0;
            write_flag_q <= 1'b0;
            write_reg_q  <= '0;
            data_q       <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            rdy_q        <= 1'b1;
            write_flag_q <= write_flag_d;
            write_reg_q  <= write_reg_d;
            data_q       <= data_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg_q[wr_ptr_q]  <= ld_reg;
            mem_data_q[wr_ptr_q] <= ld_data;
        end
    end

`ifdef WB_HAZARD_EN
    logic busy1_c, busy2_c;

    always_comb begin
        busy1_c = 1'b0;
        busy2_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (mem_reg_q[rd_ptr_q + PW'(i)] == read_reg1) busy1_c = 1'b1;
                if (mem_reg_q[rd_ptr_q + PW'(i)] == read_reg2) busy2_c = 1'b1;
            end
        end
        if (write_flag_q && (write_reg_q == read_reg1)) busy1_c = 1'b1;
        if (write_flag_q && (write_reg_q == read_reg2)) busy2_c = 1'b1;
        if (read_reg1 == 5'd0) busy1_c = 1'b0;
        if (read_reg2 == 5'd0) busy2_c = 1'b0;
    end

    assign busy1 = busy1_c;
    assign busy2 = busy2_c;
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{read_reg1, read_reg2};
    assign busy1 = 1'b0;
    assign busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: a queue-based reference model predicts each cycle's write,
// and an independent monitor compares what the DUT presents.
module tb_reg_writeback;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;
`ifdef WB_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        alu_valid = 1'b0, ld_valid = 1'b0;
    logic [4:0]  alu_reg = '0, ld_reg = '0, read_reg1 = '0, read_reg2 = '0;
    logic [31:0] alu_data = '0, ld_data = '0;
    logic        alu_stall, ld_ready, reg_write_flag, busy1, busy2;
    logic [4:0]  write_reg;
    logic [31:0] data;

    reg_writeback #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_stall(alu_stall),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
        .write_reg(write_reg), .reg_write_flag(reg_write_flag), .data(data),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .busy1(busy1), .busy2(busy2)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
    typedef struct { logic v; logic [4:0] r; logic [31:0] d; } exp_t;

    ent_t mq[$];          // model of the load FIFO, in acceptance order
    exp_t sb[$];          // expected output-register contents, one per stepped cycle
    logic        m_flag = 1'b0, m_rdy = 1'b0;
    logic [4:0]  m_wr = '0;
    logic [31:0] m_wd = '0;
    int          m_starve = 0;
    int          total = 0, bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic exp_busy(input logic [4:0] r);
        logic hit = 1'b0;
        if (m_flag && m_wr == r) hit = 1'b1;
        foreach (mq[k]) if (mq[k].r == r) hit = 1'b1;
        return HAZ && (r != 5'd0) && hit;
    endfunction

    // Monitor: one expectation per cycle, checked half a cycle after the edge that produced it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_flag", 32'(reg_write_flag), 32'(e.v));
                check("wr_reg", 32'(write_reg), 32'(e.r));
                check("wr_data", data, e.d);
            end else if (reg_write_flag) begin
                check("spurious_write", 32'(reg_write_flag), 32'd0);
            end
        end
    end

    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        ent_t h;
        bit   pushed, popped, was_empty;
        @(negedge clk);
        check("ld_ready", 32'(ld_ready), 32'(m_rdy && mq.size() < DEPTH));
        check("alu_stall", 32'(alu_stall), 32'(m_starve == STARVE_MAX));
        alu_valid = av; alu_reg = ar; alu_data = ad;
        ld_valid = lv; ld_reg = lr; ld_data = ld;
        read_reg1 = r1; read_reg2 = r2;
        #1;
        check("busy1", 32'(busy1), 32'(exp_busy(r1)));
        check("busy2", 32'(busy2), 32'(exp_busy(r2)));

        pushed    = lv && m_rdy && (mq.size() < DEPTH);
        was_empty = (mq.size() == 0);
        popped    = !av && !was_empty;
        m_flag    = 1'b0;
        if (av) begin
            if (ar != 5'd0) begin m_flag = 1'b1; m_wr = ar; m_wd = ad; end
        end else if (popped) begin
            h = mq.pop_front();
            if (h.r != 5'd0) begin m_flag = 1'b1; m_wr = h.r; m_wd = h.d; end
        end
        e.v = m_flag; e.r = m_wr; e.d = m_wd;
        sb.push_back(e);
        if (was_empty || popped) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        if (pushed) mq.push_back('{lr, ld});
        m_rdy = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 5'($urandom_range(31)), 5'($urandom_range(31)));
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        alu_valid = 0; ld_valid = 0; read_reg1 = 5'd7; read_reg2 = 5'd1;
        #1;
        check("rst_flag", 32'(reg_write_flag), 32'd0);
        check("rst_wreg", 32'(write_reg), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_stall", 32'(alu_stall), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_busy", 32'({busy1, busy2}), 32'd0);
        mq.delete(); sb.delete();
        m_flag = 0; m_wr = '0; m_wd = '0; m_starve = 0; m_rdy = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_rdy = 1'b1;
    endtask

    initial begin
        async_reset();

        // single ALU write, then idle
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        idle(2);
        // ALU write to r0 is dropped; load to r0 is consumed without a write
        step(1, 0, 32'h1234, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h55, 0, 0);
        idle(3);

        // fill with ALU held high: FIFO goes full, starvation saturates
        for (int i = 1; i <= 6; i++)
            step(1, 5'(20 + i), 32'(i * 16), 1, 5'(i <= 4 ? i : 9), 32'hA0 + 32'(i), 5'(i), 5'd9);
        step(1, 5'd30, 32'h77, 0, 0, 0, 0, 0);
        idle(6);

        // two-deep occupancy, simultaneous push/pop across several pointer laps
        step(1, 5'd2, 32'h1, 1, 5'd10, 32'hB0, 0, 0);
        step(1, 5'd3, 32'h2, 1, 5'd11, 32'hB1, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 1, 5'(12 + i), 32'hC0 + 32'(i), 5'(12 + i), 5'(11 + i));
        idle(4);

        // hazard: load to r7 pending while ALU holds the port
        step(1, 5'd4, 32'h44, 1, 5'd7, 32'h700, 7, 0);
        step(1, 5'd5, 32'h45, 0, 0, 0, 7, 0);
        step(1, 5'd6, 32'h46, 0, 0, 0, 7, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 7, 0);

        // reset while draining with three entries left
        for (int i = 0; i < 4; i++) step(1, 5'd8, 32'(i), 1, 5'(16 + i), 32'hD0 + 32'(i), 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        async_reset();
        idle(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] r1, r2;
            r1 = (mq.size() > 0 && $urandom_range(1) == 1) ? mq[0].r : 5'($urandom_range(31));
            r2 = 5'($urandom_range(31));
            step($urandom_range(99) < 45, 5'($urandom_range(31)), $urandom,
                 $urandom_range(99) < 60, 5'($urandom_range(31)), $urandom, r1, r2);
            if (i == 250) async_reset();
        end
        idle(DEPTH + 4);
        @(negedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
